// File: rtl/multicycle_ctrl_if.sv
// Instruction-field and control-strobe bundle between the multicycle datapath and its controller.
// master = datapath side, slave = controller side.
interface multicycle_ctrl_if #(
  parameter int unsigned ALU_CTRL_W = 2
) ();
  logic [3:0]            Cond;
  logic [1:0]            Op;
  logic [5:0]            Funct;
  logic [3:0]            Rd;
  logic [3:0]            ALUFlags;

  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemW;
  logic                  IRWrite;
  logic                  RegW;
  logic                  ALUSrcA;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [3:0]            State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA,
    input  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA,
    output ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset controller FSM with internal NZCV flag register.
// Define MULTICYCLE_COND_EXEC_EN to honour the Cond field; otherwise every instruction executes.
module multicycle_ctrl #(
  parameter int unsigned ALU_CTRL_W = 2,
  parameter int unsigned FETCH_WAIT = 0
) (
  input logic               CLK,
  input logic               RESETn,
  multicycle_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StExecI   = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       condexr_q, condexr_d;
  logic       cond_ex;

  logic [3:0] cmd;
  logic       is_add, is_sub, is_and, is_orr, is_cmp, is_arith, cmd_valid, rd_pc;

  assign cmd       = bus.Funct[4:1];
  assign is_add    = (cmd == 4'b0100);
  assign is_sub    = (cmd == 4'b0010);
  assign is_and    = (cmd == 4'b0000);
  assign is_orr    = (cmd == 4'b1100);
  assign is_cmp    = (cmd == 4'b1010);
  assign is_arith  = is_add | is_sub | is_cmp;
  assign cmd_valid = is_arith | is_and | is_orr;
  assign rd_pc     = (bus.Rd == 4'd15);

`ifdef MULTICYCLE_COND_EXEC_EN
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    cond_ex = 1'b1;
    case (bus.Cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = ~fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = ~fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = ~fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = ~fv;
      4'b1000: cond_ex = fc & ~fz;
      4'b1001: cond_ex = ~fc | fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = ~fz & (fn == fv);
      4'b1101: cond_ex = fz | (fn != fv);
      default: cond_ex = 1'b1;
    endcase
  end
`else
  // Flags are still tracked so enabling the macro later needs no datapath change.
  logic unused_cond;
  assign unused_cond = ^{bus.Cond, flags_q};
  assign cond_ex     = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q   <= StFetch;
      cnt_q     <= 4'd0;
      flags_q   <= 4'd0;
      condexr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      condexr_q <= condexr_d;
    end
  end

  logic       pcw, adrsrc, memw, irw, regw, alusrca;
  logic [1:0] ressrc, alusrcb, alu_ctrl;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flags_d   = flags_q;
    condexr_d = condexr_q;
    pcw       = 1'b0;
    adrsrc    = 1'b0;
    memw      = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    alusrca   = 1'b0;
    ressrc    = 2'b00;
    alusrcb   = 2'b00;
    alu_ctrl  = 2'b00;

    unique case (state_q)
      StFetch: begin
        if (cnt_q == 4'(FETCH_WAIT)) begin
          cnt_d   = 4'd0;
          state_d = StDecode;
          irw     = 1'b1;
          pcw     = 1'b1;
          alusrca = 1'b1;
          alusrcb = 2'b10;
          ressrc  = 2'b10;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDecode: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        ressrc    = 2'b10;
        condexr_d = cond_ex;
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = bus.Funct[0] ? StMemRd : StMemWr;
      StMemRd: begin
        adrsrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWr: begin
        adrsrc  = 1'b1;
        memw    = condexr_q;
        state_d = StFetch;
      end
      StMemWb: begin
        ressrc  = 2'b01;
        regw    = condexr_q & ~is_cmp & ~rd_pc;
        pcw     = condexr_q & rd_pc;
        state_d = StFetch;
      end
      StExecR, StExecI: begin
        if (is_add)                alu_ctrl = 2'b00;
        else if (is_sub || is_cmp) alu_ctrl = 2'b01;
        else if (is_and)           alu_ctrl = 2'b10;
        else if (is_orr)           alu_ctrl = 2'b11;
        if (condexr_q && cmd_valid && (bus.Funct[0] || is_cmp)) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (is_arith) flags_d[1:0] = bus.ALUFlags[1:0];
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        regw    = condexr_q & cmd_valid & ~is_cmp & ~rd_pc;
        pcw     = condexr_q & cmd_valid & ~is_cmp & rd_pc;
        state_d = StFetch;
      end
      StBranch: begin
        alusrcb = 2'b01;
        ressrc  = 2'b10;
        pcw     = condexr_q;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Strobes are masked while reset is held, since reset only takes effect at the next edge.
  always_comb begin
    bus.PCWrite    = pcw & RESETn;
    bus.MemW       = memw & RESETn;
    bus.IRWrite    = irw & RESETn;
    bus.RegW       = regw & RESETn;
    bus.AdrSrc     = adrsrc;
    bus.ALUSrcA    = alusrca;
    bus.ResultSrc  = ressrc;
    bus.ALUSrcB    = alusrcb;
    bus.ALUControl = ALU_CTRL_W'(alu_ctrl);
    bus.State      = state_q;
    case (bus.Op)
      2'b01:   bus.ImmSrc = 2'b01;
      2'b10:   bus.ImmSrc = 2'b10;
      default: bus.ImmSrc = 2'b00;
    endcase
    bus.RegSrc = {(bus.Op == 2'b01) & ~bus.Funct[0], (bus.Op == 2'b10)};
  end

endmodule
